fifo_flex: RTL
==============

Name: fifo_flex

Overview:
- Parametrised successor to the basic streaming FIFO.
- Adds four features: any depth of 2 or more (not only powers of two), a fill-level output, and programmable almost-full/almost-empty flags.
- Also adds a synchronous flush and an optional registered output stage for timing closure.
- Sits between valid/ready stream stages anywhere in the design, for example UART byte buffering or inter-pipeline decoupling.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- DEPTH, 16, total word capacity; any integer of 2 or more.
- ALMOST_FULL_LEVEL, 12, almost_full asserts when level is at least this value; range 1..DEPTH.
- ALMOST_EMPTY_LEVEL, 2, almost_empty asserts when level is at most this value; range 0..DEPTH-1.
- OUTPUT_REG, 0, output mode: 0 = fall-through combinational read; 1 = registered output stage.

Ports:
- clock  in  1  sole clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- in_data  in  DATA_WIDTH  write data.
- in_valid  in  1  write request.
- in_ready  out  1  space available.
- out_data  out  DATA_WIDTH  head word; zero when out_valid is 0.
- out_valid  out  1  head word present.
- out_ready  in  1  consumer accepts the head word.
- level  out  LW  words held, where LW = clog2(DEPTH+1).
- almost_full  out  1  level >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  level <= ALMOST_EMPTY_LEVEL.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers, level and output-stage valid go to 0.
  - in_ready=1, out_valid=0, out_data=0, level=0, almost_full=0, almost_empty=1.
  - Memory contents are not reset.
  - Reset mid-operation discards all data; no partial state survives.
- Push: occurs on in_valid && in_ready at a rising edge.
  - in_ready = !flush && (level < DEPTH).
  - in_ready never depends on out_ready, so there is no combinational path ready-to-ready.
  - When full, a simultaneous pop does not allow a push in the same cycle.
- Pop: occurs on out_valid && out_ready; out_valid is forced 0 while flush is high.
- Pointers:
  - Read and write pointers are clog2(DEPTH) bits wide.
  - They increment and wrap explicitly from DEPTH-1 to 0; they never rely on natural binary overflow.
- Level:
  - Updates by +1 on push only, -1 on pop only, and is unchanged on simultaneous push+pop.
  - Level never exceeds DEPTH and never underflows.
- Flags are decoded combinationally from the level register, so they change in the same cycle as level.
- OUTPUT_REG=0 (fall-through):
  - out_data = mem[read_pointer] when out_valid is 1, else 0.
  - out_valid = level != 0.
  - Write-to-out_valid latency is 1 cycle.
- OUTPUT_REG=1 (registered):
  - One output register holds the head word and out_valid is its occupancy bit.
  - Capacity remains DEPTH; level counts the output register plus memory.
  - The output register loads from memory when it is empty or being popped and memory is non-empty.
  - Write-to-out_valid latency is 2 cycles; after that the stream sustains 1 word/cycle.
  - out_data is 0 when the register is empty.
- Flush:
  - Flush takes priority over push and pop. Handshakes are blocked during the flush cycle because in_ready and out_valid are forced 0.
  - On the next edge, all pointers, level and output valid clear.
  - Holding flush over several cycles keeps the FIFO empty.
- Ordering: strict FIFO order in both modes; no word is duplicated or dropped except by flush or reset.

Decomposition:
- Shared constants header fifo_defs.vh:
  - clog2 function.
  - Output-mode constants OUTPUT_MODE_FALL_THROUGH=0 and OUTPUT_MODE_REGISTERED=1.
- One sub-module, fifo_flex_ram:
  - Simple dual-port memory, DEPTH x DATA_WIDTH, no reset.
  - Synchronous write port.
  - Asynchronous read port when OUTPUT_REG=0; synchronous read port when OUTPUT_REG=1.
  - Pointer, level, flag and output-stage control stay in fifo_flex.

Test Plan:
- Non-power-of-two wrap (DEPTH=5, OUTPUT_REG=0): push 0x01..0x05 -> in_ready=0, level=5, almost_full=1 (ALMOST_FULL_LEVEL=4). Then pop 3 and push 0x06..0x08 -> pops return 0x01..0x08 in order across the wrap.
- Simultaneous push+pop at level 3 for 20 cycles -> level stays 3, throughput 1 word/cycle. Full with out_ready=1 and in_valid=1 -> pop occurs, no push; level goes 5 to 4.
- Registered mode (DEPTH=16, OUTPUT_REG=1): single push of 0xA5 at cycle t -> out_valid rises at t+2 with out_data=0xA5. Continuous streaming of 32 words -> no bubbles after first word, order preserved.
- Flush at level 7 with in_valid=1 and out_ready=1 in the same cycle -> no handshake that cycle. Next cycle level=0, out_valid=0, out_data=0, almost_empty=1; a subsequent push of 0x3C is the first word read.
- Asynchronous reset: drop reset_n mid-stream between clock edges -> outputs reach reset values immediately. After release, no stale word appears: out_valid stays 0 until a new push.
- Flag thresholds (ALMOST_EMPTY_LEVEL=2, ALMOST_FULL_LEVEL=12): sweep level 0 to 16 to 0 -> almost_empty high exactly for levels 0..2, almost_full high exactly for levels 12..16, both sampled every cycle.

Source files
------------

// File: rtl/fifo_flex_pkg.sv
// Shared constants and helpers for the flexible-depth stream FIFO.
package fifo_flex_pkg;

    localparam int OUTPUT_MODE_FALL_THROUGH = 0;
    localparam int OUTPUT_MODE_REGISTERED   = 1;

    // Bits needed to index `value` distinct items (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_flex_ram.sv
// Simple dual-port word store: synchronous write, read either asynchronous or registered.
module fifo_flex_ram #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 16,
    parameter int ADDR_WIDTH      = 4,
    parameter bit REGISTERED_READ = 1'b0
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (REGISTERED_READ) begin : g_sync_read
            // The read register doubles as the FIFO output stage; it is never reset.
            always_ff @(posedge clock) begin
                if (rd_en) begin
                    rd_data <= mem[rd_addr];
                end
            end
        end else begin : g_async_read
            logic unused_rd_en;
            assign unused_rd_en = rd_en;
            assign rd_data      = mem[rd_addr];
        end
    endgenerate

endmodule

// File: rtl/fifo_flex.sv
// Stream FIFO with arbitrary depth, fill level, almost flags, synchronous flush
// and an optional registered output stage.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    parameter int OUTPUT_REG         = 0,
    localparam int LW                = clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LW-1:0]         level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int              PW           = clog2(DEPTH);
    localparam logic [PW-1:0]   LAST_ADDR    = PW'(DEPTH - 1);
    localparam logic [LW-1:0]   FULL_LEVEL   = LW'(DEPTH);
    localparam logic [LW-1:0]   AF_LEVEL     = LW'(ALMOST_FULL_LEVEL);
    localparam logic [LW-1:0]   AE_LEVEL     = LW'(ALMOST_EMPTY_LEVEL);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  push;
    logic                  pop;
    logic                  mem_rd_en;
    logic                  head_valid;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Handshake: a word moves on a rising edge where valid && ready are both high.
    // in_ready depends only on flush and level (never on out_ready), so a full FIFO
    // refuses a push even while it is being popped; flush forces both sides idle.
    assign in_ready     = !flush && (level_q < FULL_LEVEL);
    assign out_valid    = !flush && head_valid;
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign out_data     = out_valid ? ram_rd_data : '0;
    assign level        = level_q;
    assign almost_full  = (level_q >= AF_LEVEL);
    assign almost_empty = (level_q <= AE_LEVEL);

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (mem_rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    generate
        if (OUTPUT_REG == OUTPUT_MODE_REGISTERED) begin : g_registered
            logic          out_reg_valid;
            logic [LW-1:0] mem_level;

            // level counts the output register too; memory holds the remainder.
            assign mem_level  = level_q - LW'(out_reg_valid);
            assign mem_rd_en  = !flush && (!out_reg_valid || pop) && (mem_level != '0);
            assign head_valid = out_reg_valid;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    out_reg_valid <= 1'b0;
                end else if (flush) begin
                    out_reg_valid <= 1'b0;
                end else if (mem_rd_en) begin
                    out_reg_valid <= 1'b1;
                end else if (pop) begin
                    out_reg_valid <= 1'b0;
                end
            end
        end else begin : g_fall_through
            assign mem_rd_en  = pop;
            assign head_valid = (level_q != '0);
        end
    endgenerate

    fifo_flex_ram #(
        .DATA_WIDTH     (DATA_WIDTH),
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (PW),
        .REGISTERED_READ(OUTPUT_REG == OUTPUT_MODE_REGISTERED)
    ) u_ram (
        .clock  (clock),
        .wr_en  (push),
        .wr_addr(wr_ptr),
        .wr_data(in_data),
        .rd_en  (mem_rd_en),
        .rd_addr(rd_ptr),
        .rd_data(ram_rd_data)
    );

endmodule
